// File: rtl/vx_packet_arbiter.sv
// Packet-granular least-recently-granted arbiter with a single registered output stage.
// Optional build macro VX_PACKET_ARB_PERF_EN adds the perf_stalls / perf_packets counters.
module vx_packet_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int DATAW        = 32,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  input  logic [NUM_REQS-1:0]       last_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic                      last_out,
  output logic [LOG_NUM_REQS-1:0]   sel_out,
  input  logic                      ready_out,
  output logic                      locked
`ifdef VX_PACKET_ARB_PERF_EN
  ,
  output logic [31:0]               perf_stalls,
  output logic [31:0]               perf_packets
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [LOG_NUM_REQS-1:0]   lock_idx_reg, lock_idx_next;

  logic                      valid_out_reg;
  logic [DATAW-1:0]          data_out_reg;
  logic                      last_out_reg;
  logic [LOG_NUM_REQS-1:0]   sel_out_reg;

  logic [NUM_REQS-1:0]       grant;
  logic [LOG_NUM_REQS-1:0]   grant_idx;
  logic [NUM_REQS-1:0]       lock_onehot;
  logic [NUM_REQS-1:0]       sel_onehot;
  logic [LOG_NUM_REQS-1:0]   sel_idx;
  logic                      stage_free;
  logic                      accept;
  logic                      accept_last;
  logic                      prio_update;
  logic [DATAW-1:0]          data_mux;

  // Least-recently-granted winner: pairwise priority bits, one register per pair i<j.
  generate
    if (NUM_REQS == 1) begin : g_single
      assign grant = valid_in;
    end else begin : g_matrix
      logic [NUM_REQS*NUM_REQS-1:0] beats;

      for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_row
        for (genvar gj = 0; gj < NUM_REQS; gj++) begin : g_col
          if (gi == gj) begin : g_diag
            assign beats[gi*NUM_REQS+gj] = 1'b1;
          end else if (gi < gj) begin : g_pair
            logic prio_bit_reg;

            always_ff @(posedge clk) begin
              if (reset) begin
                prio_bit_reg <= 1'b1;
              end else if (prio_update) begin
                if (grant[gi]) begin
                  prio_bit_reg <= 1'b0;
                end else if (grant[gj]) begin
                  prio_bit_reg <= 1'b1;
                end
              end
            end

            assign beats[gi*NUM_REQS+gj] = prio_bit_reg;
            assign beats[gj*NUM_REQS+gi] = !prio_bit_reg;
          end
        end

        // Requester gi wins if it beats every other active requester.
        assign grant[gi] = valid_in[gi] && (&(beats[gi*NUM_REQS +: NUM_REQS] | ~valid_in));
      end
    end
  endgenerate

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) begin
        grant_idx = LOG_NUM_REQS'(i);
      end
    end
  end

  always_comb begin
    lock_onehot = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      lock_onehot[i] = (lock_idx_reg == LOG_NUM_REQS'(i));
    end
  end

  assign stage_free = !valid_out_reg || ready_out;
  assign sel_onehot = (state_reg == ST_LOCK) ? lock_onehot : grant;
  assign sel_idx    = (state_reg == ST_LOCK) ? lock_idx_reg : grant_idx;

  // Held low during reset so nothing is accepted from a packet that is being dropped.
  assign ready_in    = (stage_free && !reset) ? sel_onehot : '0;
  assign accept      = |(valid_in & ready_in);
  assign accept_last = |(valid_in & ready_in & last_in);
  assign prio_update = accept && (state_reg == ST_IDLE);

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (ready_in[i]) begin
        data_mux = data_in[i*DATAW +: DATAW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      lock_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lock_idx_next = lock_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && !accept_last) begin
          state_next    = ST_LOCK;
          lock_idx_next = grant_idx;
        end
      end
      ST_LOCK: begin
        if (accept && accept_last) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Load on accept, drain when consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
      last_out_reg  <= 1'b0;
      sel_out_reg   <= '0;
    end else if (accept) begin
      valid_out_reg <= 1'b1;
      data_out_reg  <= data_mux;
      last_out_reg  <= accept_last;
      sel_out_reg   <= sel_idx;
    end else if (ready_out) begin
      valid_out_reg <= 1'b0;
    end
  end

  assign valid_out = valid_out_reg;
  assign data_out  = data_out_reg;
  assign last_out  = last_out_reg;
  assign sel_out   = sel_out_reg;
  assign locked    = (state_reg == ST_LOCK);

`ifdef VX_PACKET_ARB_PERF_EN
  logic [31:0] perf_stalls_reg;
  logic [31:0] perf_packets_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls_reg  <= '0;
      perf_packets_reg <= '0;
    end else begin
      if (valid_out_reg && !ready_out) begin
        perf_stalls_reg <= perf_stalls_reg + 32'd1;
      end
      if (valid_out_reg && ready_out && last_out_reg) begin
        perf_packets_reg <= perf_packets_reg + 32'd1;
      end
    end
  end

  assign perf_stalls  = perf_stalls_reg;
  assign perf_packets = perf_packets_reg;
`endif

  // A waiting requester must keep its beat offered until it is accepted.
  generate
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_hold_chk
      a_valid_hold : assert property (@(posedge clk) disable iff (reset)
        (valid_in[gi] && !ready_in[gi]) |=> valid_in[gi]);
    end
  endgenerate

endmodule

// File: tb/tb_vx_packet_arbiter.sv
// Directed bench for vx_packet_arbiter (NUM_REQS=4, DATAW=8); one task per scenario.
module tb_vx_packet_arbiter;

  localparam int NUM_REQS = 4;
  localparam int DATAW    = 8;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQS-1:0]       valid_in;
  logic [NUM_REQS*DATAW-1:0] data_in;
  logic [NUM_REQS-1:0]       last_in;
  logic [NUM_REQS-1:0]       ready_in;
  logic                      valid_out;
  logic [DATAW-1:0]          data_out;
  logic                      last_out;
  logic [1:0]                sel_out;
  logic                      ready_out;
  logic                      locked;
`ifdef VX_PACKET_ARB_PERF_EN
  logic [31:0]               perf_stalls;
  logic [31:0]               perf_packets;
`endif

  int vectors;
  int miscompares;

  vx_packet_arbiter #(
    .NUM_REQS (NUM_REQS),
    .DATAW    (DATAW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .last_out  (last_out),
    .sel_out   (sel_out),
    .ready_out (ready_out),
    .locked    (locked)
`ifdef VX_PACKET_ARB_PERF_EN
    ,
    .perf_stalls  (perf_stalls),
    .perf_packets (perf_packets)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid_out, sel_out, data_out, last_out, locked}
  logic [12:0] obs;
  assign obs = {valid_out, sel_out, data_out, last_out, locked};

  task automatic drive_req(input int i, input logic [7:0] d, input logic l);
    data_in[i*DATAW +: DATAW] = d;
    last_in[i] = l;
  endtask

  // Called at a negedge; leaves the bench at the negedge after the reset edge.
  task automatic do_reset();
    reset = 1'b1;
    valid_in = '0;
    data_in = '0;
    last_in = '0;
    ready_out = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in = '0;
    data_in = '0;
    last_in = '0;
    ready_out = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== 13'h0) begin
      $display("FAIL reset_outputs obs=%h expected=%h", obs, 13'h0);
      miscompares++;
    end
    valid_in = 4'b0100;
    #1;
    vectors++;
    if (ready_in !== 4'b0000) begin
      $display("FAIL reset_ready ready_in=%b expected=%b", ready_in, 4'b0000);
      miscompares++;
    end
    valid_in = '0;
`ifdef VX_PACKET_ARB_PERF_EN
    vectors++;
    if ({perf_stalls, perf_packets} !== 64'h0) begin
      $display("FAIL reset_perf stalls=%0d packets=%0d expected=0/0", perf_stalls, perf_packets);
      miscompares++;
    end
`endif
    reset = 1'b0;
    #1;
    vectors++;
    if (ready_in !== 4'b0000) begin
      $display("FAIL idle_no_valid ready_in=%b expected=%b", ready_in, 4'b0000);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (obs !== 13'h0) begin
      $display("FAIL idle_no_grant obs=%h expected=%h", obs, 13'h0);
      miscompares++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  es;
    logic [12:0] exp_obs;
    do_reset();
    for (int i = 0; i < NUM_REQS; i++) drive_req(i, 8'(8'h10 + i), 1'b1);
    valid_in = 4'b1111;
    #1;
    vectors++;
    if (ready_in !== 4'b0001) begin
      $display("FAIL rr_first_ready ready_in=%b expected=%b", ready_in, 4'b0001);
      miscompares++;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      es = 2'(k % 4);
      exp_obs = {1'b1, es, 8'(8'h10 + es), 1'b1, 1'b0};
      vectors++;
      if (obs !== exp_obs) begin
        $display("FAIL rr_beat%0d obs=%h expected=%h", k, obs, exp_obs);
        miscompares++;
      end
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    drive_req(0, 8'h55, 1'b1);
    valid_in = 4'b0001;
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd0, 8'h55, 1'b1, 1'b0}) begin
      $display("FAIL lock_pre obs=%h expected=%h", obs, {1'b1, 2'd0, 8'h55, 1'b1, 1'b0});
      miscompares++;
    end
    drive_req(0, 8'hC0, 1'b1);
    drive_req(1, 8'hA0, 1'b0);
    drive_req(2, 8'hC2, 1'b1);
    valid_in = 4'b0111;
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd1, 8'hA0, 1'b0, 1'b1}) begin
      $display("FAIL lock_beat0 obs=%h expected=%h", obs, {1'b1, 2'd1, 8'hA0, 1'b0, 1'b1});
      miscompares++;
    end
    vectors++;
    if (ready_in !== 4'b0010) begin
      $display("FAIL lock_holdoff ready_in=%b expected=%b", ready_in, 4'b0010);
      miscompares++;
    end
    drive_req(1, 8'hA1, 1'b0);
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd1, 8'hA1, 1'b0, 1'b1}) begin
      $display("FAIL lock_beat1 obs=%h expected=%h", obs, {1'b1, 2'd1, 8'hA1, 1'b0, 1'b1});
      miscompares++;
    end
    drive_req(1, 8'hA2, 1'b1);
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd1, 8'hA2, 1'b1, 1'b0}) begin
      $display("FAIL lock_beat2 obs=%h expected=%h", obs, {1'b1, 2'd1, 8'hA2, 1'b1, 1'b0});
      miscompares++;
    end
    valid_in = 4'b0101;
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd2, 8'hC2, 1'b1, 1'b0}) begin
      $display("FAIL lock_next_req2 obs=%h expected=%h", obs, {1'b1, 2'd2, 8'hC2, 1'b1, 1'b0});
      miscompares++;
    end
    valid_in = 4'b0001;
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd0, 8'hC0, 1'b1, 1'b0}) begin
      $display("FAIL lock_next_req0 obs=%h expected=%h", obs, {1'b1, 2'd0, 8'hC0, 1'b1, 1'b0});
      miscompares++;
    end
    valid_in = '0;
    @(negedge clk);
    vectors++;
    if (valid_out !== 1'b0) begin
      $display("FAIL lock_drain valid_out=%b expected=0", valid_out);
      miscompares++;
    end
  endtask

  task automatic test_backpressure();
`ifdef VX_PACKET_ARB_PERF_EN
    logic [31:0] stall_base;
`endif
    do_reset();
    drive_req(3, 8'hD0, 1'b0);
    valid_in = 4'b1000;
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd3, 8'hD0, 1'b0, 1'b1}) begin
      $display("FAIL bp_beat0 obs=%h expected=%h", obs, {1'b1, 2'd3, 8'hD0, 1'b0, 1'b1});
      miscompares++;
    end
`ifdef VX_PACKET_ARB_PERF_EN
    stall_base = perf_stalls;
`endif
    drive_req(3, 8'hD1, 1'b0);
    ready_out = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({obs, ready_in} !== {1'b1, 2'd3, 8'hD0, 1'b0, 1'b1, 4'b0000}) begin
        $display("FAIL bp_hold%0d obs=%h ready_in=%b expected=%h/0000", k, obs, ready_in,
                 {1'b1, 2'd3, 8'hD0, 1'b0, 1'b1});
        miscompares++;
      end
    end
`ifdef VX_PACKET_ARB_PERF_EN
    vectors++;
    if (perf_stalls - stall_base !== 32'd5) begin
      $display("FAIL bp_perf_stalls delta=%0d expected=5", perf_stalls - stall_base);
      miscompares++;
    end
`endif
    ready_out = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd3, 8'hD1, 1'b0, 1'b1}) begin
      $display("FAIL bp_beat1 obs=%h expected=%h", obs, {1'b1, 2'd3, 8'hD1, 1'b0, 1'b1});
      miscompares++;
    end
    drive_req(3, 8'hD2, 1'b1);
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd3, 8'hD2, 1'b1, 1'b0}) begin
      $display("FAIL bp_beat2 obs=%h expected=%h", obs, {1'b1, 2'd3, 8'hD2, 1'b1, 1'b0});
      miscompares++;
    end
    valid_in = '0;
    @(negedge clk);
    vectors++;
    if (valid_out !== 1'b0) begin
      $display("FAIL bp_drain valid_out=%b expected=0", valid_out);
      miscompares++;
    end
  endtask

  task automatic test_lru();
    logic [1:0] es;
    do_reset();
    drive_req(3, 8'hE3, 1'b1);
    valid_in = 4'b1000;
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd3, 8'hE3, 1'b1, 1'b0}) begin
      $display("FAIL lru_pre obs=%h expected=%h", obs, {1'b1, 2'd3, 8'hE3, 1'b1, 1'b0});
      miscompares++;
    end
    for (int i = 0; i < NUM_REQS; i++) drive_req(i, 8'(8'h20 + i), 1'b1);
    valid_in = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      es = 2'(k);
      vectors++;
      if ({valid_out, sel_out, data_out} !== {1'b1, es, 8'(8'h20 + es)}) begin
        $display("FAIL lru_order%0d sel_out=%0d data_out=%h expected=%0d/%h", k, sel_out,
                 data_out, es, 8'(8'h20 + es));
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive_req(2, 8'hF0, 1'b0);
    valid_in = 4'b0100;
    @(negedge clk);
    drive_req(2, 8'hF1, 1'b0);
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd2, 8'hF1, 1'b0, 1'b1}) begin
      $display("FAIL rmp_beat1 obs=%h expected=%h", obs, {1'b1, 2'd2, 8'hF1, 1'b0, 1'b1});
      miscompares++;
    end
    reset = 1'b1;
    drive_req(0, 8'h30, 1'b1);
    drive_req(2, 8'hF0, 1'b0);
    valid_in = 4'b0101;
    @(negedge clk);
    vectors++;
    if ({valid_out, locked, ready_in} !== 6'b0) begin
      $display("FAIL rmp_cleared valid_out=%b locked=%b ready_in=%b expected=0/0/0000",
               valid_out, locked, ready_in);
      miscompares++;
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (ready_in !== 4'b0001) begin
      $display("FAIL rmp_ready ready_in=%b expected=%b", ready_in, 4'b0001);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd0, 8'h30, 1'b1, 1'b0}) begin
      $display("FAIL rmp_req0_wins obs=%h expected=%h", obs, {1'b1, 2'd0, 8'h30, 1'b1, 1'b0});
      miscompares++;
    end
    valid_in = 4'b0100;
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 2'd2, 8'hF0, 1'b0, 1'b1}) begin
      $display("FAIL rmp_resend obs=%h expected=%h", obs, {1'b1, 2'd2, 8'hF0, 1'b0, 1'b1});
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_req(0, 8'h40, 1'b1);
    valid_in = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== {1'b1, 2'd0, 8'(8'h40 + k), 1'b1, 1'b0}) begin
        $display("FAIL b2b_beat%0d obs=%h expected=%h", k, obs,
                 {1'b1, 2'd0, 8'(8'h40 + k), 1'b1, 1'b0});
        miscompares++;
      end
      if (k < 7) drive_req(0, 8'(8'h41 + k), 1'b1);
      else valid_in = '0;
    end
    @(negedge clk);
    vectors++;
    if (valid_out !== 1'b0) begin
      $display("FAIL b2b_drain valid_out=%b expected=0", valid_out);
      miscompares++;
    end
`ifdef VX_PACKET_ARB_PERF_EN
    vectors++;
    if (perf_packets !== 32'd8) begin
      $display("FAIL b2b_perf_packets perf_packets=%0d expected=8", perf_packets);
      miscompares++;
    end
`endif
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    valid_in = '0;
    data_in = '0;
    last_in = '0;
    ready_out = 1'b1;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_lru();
    test_reset_mid_packet();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vx_packet_arbiter.md
Name: vx_packet_arbiter

Overview:
- Shares one valid/ready output stream among NUM_REQS requesters at packet granularity.
- Arbitration is least-recently-granted, using a matrix priority scheme.
- The grant is held from the first beat of a packet through its last beat.
- A single registered output stage decouples the output from the inputs. Sits in front of shared resources such as a memory port, a writeback bus or a cache bank input.

Parameters:
- NUM_REQS, 4, number of requesters; >=1; NUM_REQS==1 degenerates to a registered pass-through.
- DATAW, 32, payload width per beat.
- LOG_NUM_REQS, max(1,$clog2(NUM_REQS)), width of sel_out.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  NUM_REQS  per-requester beat valid
- data_in  in  NUM_REQS*DATAW  payloads; requester i occupies bits [i*DATAW +: DATAW]
- last_in  in  NUM_REQS  beat is final beat of its packet
- ready_in  out  NUM_REQS  per-requester accept
- valid_out  out  1  output beat valid
- data_out  out  DATAW  output payload
- last_out  out  1  output beat is last of its packet
- sel_out  out  LOG_NUM_REQS  source index of the output beat
- ready_out  in  1  downstream accept
- locked  out  1  a multi-beat packet is in flight (FSM in LOCK)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: valid_out=0, last_out=0, sel_out=0, data_out=0, locked=0, FSM=IDLE, priority=index order (0 highest).
- Input handshake: a beat from requester i transfers when valid_in[i] && ready_in[i].
- Output handshake: a beat transfers when valid_out && ready_out.
- stage_free = !valid_out || ready_out.
- Ready rule: ready_in[i] = stage_free && (i == current selection). At most one ready_in bit is high per cycle.
- ready_in never depends on any valid_in other than the winner's.
- Selection in IDLE: combinational least-recently-granted winner among asserted valid_in.
- Priority matrix: pairwise bit p[i][j] for i<j, meaning i beats j.
- Selection in LOCK: the registered lock index; all other requesters are held off.
- Latency: an accepted beat appears on the output the next cycle. Throughput is 1 beat/cycle with ready_out held high.
- Output register load: when an input beat is accepted, data_out, last_out, sel_out and valid_out=1 load.
- Output register drain: when the output is consumed and no input beat is accepted, valid_out clears.
- Output register hold: while valid_out && !ready_out, all outputs hold stable.
- FSM IDLE -> LOCK: first beat of requester w accepted with last_in[w]=0; lock index <= w.
- FSM IDLE -> IDLE: accepted beat has last_in=1 (single-beat packet), or no beat accepted.
- FSM LOCK -> IDLE: beat accepted from the lock index with last_in=1.
- FSM LOCK -> LOCK: no beat accepted. The lock holds indefinitely even if the locked requester drops valid; there is no timeout.
- Priority update: once per packet, on acceptance of the first beat (in IDLE).
  - The winner w becomes lowest priority: p[w][*]=0, p[*][w]=1.
  - Pairs not involving w are unchanged.
  - Beats accepted in LOCK never update priority.
- Simultaneous events: output drain and input accept in the same cycle means the register reloads with no bubble.
- Last-beat accept and new request: other requesters may win in the very next cycle.
- No valid_in in IDLE: no grant, no priority change.
- Reset mid-packet: in-flight packet dropped; the output beat is discarded; FSM, priority and outputs return to reset values.
- Upstream sources must re-send the packet from its first beat after reset.
- Assertion (sim only): valid_in[i] must not drop while ready_in[i]=0 after being asserted.

Optional Feature:
- Macro: VX_PACKET_ARB_PERF_EN.
- With the macro defined, two extra outputs are added, both reset to 0 and wrapping modulo 2^32:
  - perf_stalls (out, 32): counts cycles with valid_out && !ready_out.
  - perf_packets (out, 32): counts output transfers with last_out=1.
- Without the macro, these ports and counters are absent. Functional behaviour is identical either way.

Test Plan:
- Round-robin order (NUM_REQS=4, DATAW=8): all valid_in=4'b1111 with single-beat packets, data=0x10+i, ready_out=1.
  - Required: sel_out sequence 0,1,2,3,0,1..., one beat per cycle, first beat one cycle after the first accept.
- Packet lock: req1 sends 3 beats (0xA0,0xA1,0xA2 with last on 0xA2) while req0 and req2 hold valid.
  - Required: output 0xA0,0xA1,0xA2 contiguous with sel_out=1 and locked=1 for 2 cycles; then req2 wins, then req0.
- Backpressure: ready_out=0 for 5 cycles mid-packet.
  - Required: data_out and sel_out stable, all ready_in=0, perf_stalls advances by 5 (PERF_EN); no beat lost or duplicated when ready_out returns.
- LRU update: from reset, req3 alone sends one packet; then all four request.
  - Required: order 0,1,2,3, because req3 was demoted.
- Reset mid-packet: assert reset after beat 2 of a 4-beat packet from req2.
  - Required next cycle: valid_out=0, locked=0, ready_in=0.
  - After release, with req0 and req2 valid, req0 wins.
- Zero-bubble streaming: 8 back-to-back single-beat packets from req0 alone with ready_out=1.
  - Required: valid_out high for 8 consecutive cycles; perf_packets=8 (PERF_EN).
